st_align_unit: RTL and testbench

ST_ALIGN_UNIT -- requirements
Module: st_align_unit

---
 rtl/rv_mem_pkg.sv | 31 +++
 rtl/st_lane_gen.sv | 24 ++
 rtl/st_align_unit.sv | 119 +++++++++++
 tb/tb_st_align_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared memory-op definitions: load/store func3 codes, store-FSM states and
// the size-to-byte-mask helper.
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } st_state_e;

  // All-zero mask marks a func3 that is not a store size.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_SB:   size_mask = 4'b0001;
      F3_SH:   size_mask = 4'b0011;
      F3_SW:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/st_lane_gen.sv
// Combinational lane placement: shifts right-aligned store data and its byte
// strobe into a two-word (64-bit) window starting at byte offset off.
module st_lane_gen
  import rv_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [63:0] shifted,
  output logic [7:0]  strobe,
  output logic        illegal
);

  logic [3:0]  mask;
  logic [31:0] data_m;

  assign mask    = size_mask(func3);
  assign illegal = (mask == 4'b0000);
  // Bytes beyond the store size are zeroed before shifting so unused lanes stay 0.
  assign data_m  = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign shifted = {32'b0, data_m} << {off, 3'b000};
  assign strobe  = {4'b0000, mask} << off;

endmodule

// File: rtl/st_align_unit.sv
// Store alignment unit: turns a sized byte-address store into one or two
// word-aligned write beats with byte strobes, or rejects it.
module st_align_unit
  import rv_mem_pkg::*;
#(
  parameter int SPLIT_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        misalign_err,
  output logic        func_err
);

  st_state_e   state_q;
  logic [31:0] mem_addr_q, mem_wdata_q, hi_wdata_q;
  logic [3:0]  mem_wstrb_q, hi_wstrb_q;
  logic        done_q, misalign_q, func_err_q;

  logic [63:0] lg_shifted;
  logic [7:0]  lg_strobe;
  logic        lg_illegal;
  logic        needs_b1;

  st_lane_gen u_lane (
    .func3   (func3),
    .off     (addr[1:0]),
    .data    (st_data),
    .shifted (lg_shifted),
    .strobe  (lg_strobe),
    .illegal (lg_illegal)
  );

  assign needs_b1 = (lg_strobe[7:4] != 4'b0000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      hi_wdata_q  <= '0;
      hi_wstrb_q  <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      func_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      func_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (lg_illegal) begin
              done_q     <= 1'b1;
              func_err_q <= 1'b1;
            end else if (needs_b1 && (SPLIT_EN == 0)) begin
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              // Both beats are captured now; the upper word waits in hi_* until beat 0 retires.
              state_q     <= ST_BEAT0;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= lg_shifted[31:0];
              mem_wstrb_q <= lg_strobe[3:0];
              hi_wdata_q  <= lg_shifted[63:32];
              hi_wstrb_q  <= lg_strobe[7:4];
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
            if (hi_wstrb_q != 4'b0000) begin
              state_q     <= ST_BEAT1;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_wdata_q <= hi_wdata_q;
              mem_wstrb_q <= hi_wstrb_q;
            end else begin
              state_q     <= ST_IDLE;
              mem_wstrb_q <= 4'b0000;
              done_q      <= 1'b1;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            state_q     <= ST_IDLE;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_wstrb_q <= 4'b0000;
        end
      endcase
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign mem_valid    = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign done         = done_q;
  assign misalign_err = misalign_q;
  assign func_err     = func_err_q;

endmodule

// File: tb/tb_st_align_unit.sv
// Bench for st_align_unit: byte-level store model plus per-cycle compare of
// the split-enabled instance, and directed checks of a split-disabled instance.
module tb_st_align_unit;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_ready = 1'b1;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = '0, st_data = '0;
  logic        req_ready, mem_valid, done, misalign_err, func_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        ns_req_valid = 1'b0, ns_mem_ready = 1'b1;
  logic [2:0]  ns_func3 = 3'b000;
  logic [31:0] ns_addr = '0, ns_st_data = '0;
  logic        ns_req_ready, ns_mem_valid, ns_done, ns_mis, ns_ferr;
  logic [31:0] ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_wstrb;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  st_align_unit #(.SPLIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .func3(func3), .addr(addr), .st_data(st_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .done(done), .misalign_err(misalign_err), .func_err(func_err)
  );

  st_align_unit #(.SPLIT_EN(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .func3(ns_func3), .addr(ns_addr), .st_data(ns_st_data), .mem_valid(ns_mem_valid),
    .mem_ready(ns_mem_ready), .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
    .mem_wstrb(ns_mem_wstrb), .done(ns_done), .misalign_err(ns_mis), .func_err(ns_ferr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte-level model: byte i of the store lands at address addr+i; bytes are
  // grouped by the word they fall in, one beat per word touched.
  logic [31:0] m_a[2], m_d[2];
  logic [3:0]  m_s[2];
  int          m_n, m_kind;  // kind: 1 ok, 2 func_err, 3 misalign_err

  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input bit split);
    int n;
    logic [31:0] ba, w;
    int lane;
    m_n = 0; m_kind = 1;
    case (f3)
      3'b000:  n = 1;
      3'b001:  n = 2;
      3'b010:  n = 4;
      default: n = 0;
    endcase
    if (n == 0) begin m_kind = 2; return; end
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      w = {ba[31:2], 2'b00};
      lane = int'(ba[1:0]);
      if (m_n == 0 || m_a[m_n-1] != w) begin
        m_a[m_n] = w; m_d[m_n] = '0; m_s[m_n] = '0; m_n++;
      end
      m_d[m_n-1][8*lane +: 8] = d[8*i +: 8];
      m_s[m_n-1][lane] = 1'b1;
    end
    if (m_n == 2 && !split) begin m_kind = 3; m_n = 0; end
  endtask

  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] s;} beat_t;
  beat_t exp_q[$];
  bit    busy = 1'b0, exp_done = 1'b0, rst_prev = 1'b0;
  int    exp_kind = 0;

  always @(negedge clk) begin
    if (!rst_prev) begin
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_done", 32'({done, misalign_err, func_err}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      if (done) begin
        chk("func_err", 32'(func_err), 32'(exp_kind == 2));
        chk("misalign_err", 32'(misalign_err), 32'(exp_kind == 3));
      end else begin
        chk("err_without_done", 32'({misalign_err, func_err}), 32'd0);
      end
      chk("mem_valid", 32'(mem_valid), 32'(busy));
      if (mem_valid && busy) begin
        chk("mem_addr", mem_addr, exp_q[0].a);
        chk("mem_wdata", mem_wdata, exp_q[0].d);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_q[0].s));
      end
      if (!mem_valid) chk("wstrb_idle", 32'(mem_wstrb), 32'd0);
      chk("req_ready", 32'(req_ready), 32'(!busy));
    end
    exp_done = 1'b0; exp_kind = 0;
    if (!rst_n) begin
      busy = 1'b0; exp_q.delete();
    end else if (busy) begin
      if (mem_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin busy = 1'b0; exp_done = 1'b1; exp_kind = 1; end
      end
    end else if (req_valid) begin
      model(func3, addr, st_data, 1'b1);
      if (m_kind != 1) begin
        exp_done = 1'b1; exp_kind = m_kind;
      end else begin
        for (int i = 0; i < m_n; i++) exp_q.push_back('{a: m_a[i], d: m_d[i], s: m_s[i]});
        busy = 1'b1;
      end
    end
    rst_prev = rst_n;
  end

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic mr);
    @(posedge clk); #1;
    req_valid = v; func3 = f3; addr = a; st_data = d; mem_ready = mr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic ns_issue(input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    ns_req_valid = 1'b1; ns_func3 = f3; ns_addr = a; ns_st_data = 32'h55661234;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r;
    // Pin the model to hand-computed beats.
    model(F3_SW, 32'h100, 32'hDEADBEEF, 1'b1);
    chk("pin_sw_n", 32'(m_n), 32'd1);
    chk("pin_sw_beat", m_a[0] ^ m_d[0] ^ 32'(m_s[0]), 32'h100 ^ 32'hDEADBEEF ^ 32'hF);
    model(F3_SB, 32'h203, 32'h000000AB, 1'b1);
    chk("pin_sb_wdata", m_d[0], 32'hAB000000);
    chk("pin_sb_wstrb", 32'(m_s[0]), 32'h8);
    model(F3_SH, 32'h303, 32'h1234, 1'b1);
    chk("pin_sh_b0", {m_a[0][15:0], m_d[0][31:24], 4'h0, m_s[0]}, 32'h0300_3408);
    chk("pin_sh_b1", {m_a[1][15:0], m_d[1][7:0], 4'h0, m_s[1]}, 32'h0304_1201);
    model(F3_SW, 32'hFFFFFFFE, 32'h11223344, 1'b1);
    chk("pin_wrap_a0", m_a[0], 32'hFFFFFFFC);
    chk("pin_wrap_d0", m_d[0], 32'h33440000);
    chk("pin_wrap_a1", m_a[1], 32'h00000000);
    chk("pin_wrap_d1", m_d[1], 32'h00001122);
    chk("pin_wrap_s", 32'({m_s[0], m_s[1]}), 32'hC3);
    model(3'b011, 32'h0, 32'h0, 1'b1);
    chk("pin_func_kind", 32'(m_kind), 32'd2);
    model(F3_SH, 32'h3, 32'h0, 1'b0);
    chk("pin_mis_kind", 32'(m_kind), 32'd3);

    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Split-disabled instance, directed.
    ns_issue(F3_SH, 32'h3);
    chk("ns_mis_done", 32'({ns_done, ns_mis, ns_ferr, ns_mem_valid}), 32'b1100);
    ns_issue(3'b011, 32'h0);
    chk("ns_func_done", 32'({ns_done, ns_mis, ns_ferr, ns_mem_valid}), 32'b1010);
    ns_issue(3'b111, 32'h3);
    chk("ns_func_prio", 32'({ns_done, ns_mis, ns_ferr, ns_mem_valid}), 32'b1010);
    ns_issue(F3_SH, 32'h302);
    chk("ns_beat_valid", 32'({ns_mem_valid, ns_done}), 32'b10);
    chk("ns_beat_addr", ns_mem_addr, 32'h300);
    chk("ns_beat_wdata", ns_mem_wdata, 32'h12340000);
    chk("ns_beat_wstrb", 32'(ns_mem_wstrb), 32'hC);
    @(negedge clk);
    chk("ns_beat_done", 32'({ns_mem_valid, ns_done, ns_mem_wstrb}), 32'b010000);

    // Split-enabled instance, directed cases; the monitor does the checking.
    drive(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 1'b1); idle(3);
    drive(1'b1, F3_SB, 32'h203, 32'h000000AB, 1'b1); idle(3);
    drive(1'b1, F3_SH, 32'h303, 32'h00001234, 1'b1); idle(4);
    drive(1'b1, F3_SW, 32'hFFFFFFFE, 32'h11223344, 1'b0);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    idle(4);
    drive(1'b1, 3'b011, 32'h40, 32'h0, 1'b1); idle(2);
    // Back-to-back: new request in the cycle done pulses.
    drive(1'b1, F3_SW, 32'h100, 32'h01020304, 1'b1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    drive(1'b1, F3_SB, 32'h5, 32'hFFFFFF77, 1'b1);
    idle(3);
    // Reset while in the second beat, then an immediate new request.
    drive(1'b1, F3_SH, 32'h303, 32'h00001234, 1'b1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, F3_SW, 32'h100, 32'hCAFEF00D, 1'b1);
    rst_n = 1'b1;
    idle(3);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 299) != 0);
      req_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      func3 = (r < 3) ? F3_SB : (r < 6) ? F3_SH : (r < 9) ? F3_SW : 3'($urandom_range(3, 7));
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      st_data = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    idle(10);
    @(negedge clk);
    chk("drain_idle", 32'({req_ready, mem_valid}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
